mem_port_arbiter: RTL and testbench

- Shares the single memory port between instruction fetch and load/store requesters.
- Sits between the core front end / LSU and the Mem data port. Lets a multi-cycle core use one fixed-latency memory.
- Arbitrates using data priority with a fetch anti-starvation limit. Sequences each access over LATENCY cycles and returns one registered response per request.
- Rejects misaligned or invalid-size requests with an error response, without touching memory.

---
 rtl/mem_port_arbiter_pkg.sv | 34 +++
 rtl/mem_arb_grant.sv | 29 ++
 rtl/mem_port_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the fetch/data memory port arbiter.
// Size codes, FSM states, owners and the fault predicate.
package mem_port_arbiter_pkg;

  localparam logic [1:0] SIZE_BYTE  = 2'b00;
  localparam logic [1:0] SIZE_HWORD = 2'b01;
  localparam logic [1:0] SIZE_WORD  = 2'b10;

  typedef enum logic {
    ST_IDLE,
    ST_ACCESS
  } state_t;

  typedef enum logic {
    OWN_IF,
    OWN_D
  } owner_t;

  // High for an illegal size or an address not aligned to the size.
  function automatic logic misaligned(
    input logic [1:0] addr_lo,
    input logic [1:0] size
  );
    logic bad;
    case (size)
      SIZE_BYTE:  bad = 1'b0;
      SIZE_HWORD: bad = addr_lo[0];
      SIZE_WORD:  bad = |addr_lo;
      default:    bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_arb_grant.sv
// Combinational grant: data first, fetch once data has
// won STARVE_LIMIT times in a row over a waiting fetch.
module mem_arb_grant
  import mem_port_arbiter_pkg::*;
#(
  parameter int SCW          = 3,
  parameter int STARVE_LIMIT = 4
) (
  input  logic           if_valid,
  input  logic           d_valid,
  input  logic [SCW-1:0] starve_cnt,
  input  logic           idle,
  output logic           if_ready,
  output logic           d_ready,
  output owner_t         grant_owner
);

  logic starved;

  assign starved = (starve_cnt == SCW'(STARVE_LIMIT));

  // Exactly one ready at most, and only while idle.
  always_comb begin
    d_ready     = idle & d_valid & ~(if_valid & starved);
    if_ready    = idle & if_valid & ~d_ready;
    grant_owner = d_ready ? OWN_D : OWN_IF;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory port between fetch and
// load/store; one registered response per request.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int LATENCY      = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_valid,
  output logic        if_req_ready,
  input  logic [31:0] if_addr,
  output logic        if_rsp_valid,
  output logic [31:0] if_rsp_data,
  output logic        if_rsp_err,
  input  logic        d_req_valid,
  output logic        d_req_ready,
  input  logic [31:0] d_addr,
  input  logic [1:0]  d_size,
  input  logic        d_we,
  input  logic [31:0] d_wdata,
  output logic        d_rsp_valid,
  output logic [31:0] d_rsp_data,
  output logic        d_rsp_err,
  output logic [31:0] mem_addr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata
);

  localparam int SCW = $clog2(STARVE_LIMIT + 1);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t         state;
  state_t         state_nx;
  logic [3:0]     cnt;
  logic [SCW-1:0] starve_cnt;

  logic [31:0] lat_addr;
  logic [1:0]  lat_size;
  logic        lat_we;
  logic [31:0] lat_wdata;
  owner_t      lat_owner;

  logic        idle;
  owner_t      grant_owner;
  logic        acc_if;
  logic        acc_d;
  logic        accept;
  logic        from_d;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_we;
  logic [31:0] req_wdata;
  logic        req_bad;
  logic        last;

  // Readies are held low while reset is asserted.
  assign idle = (state == ST_IDLE) & rst;

  mem_arb_grant #(
    .SCW          (SCW),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_grant (
    .if_valid    (if_req_valid),
    .d_valid     (d_req_valid),
    .starve_cnt  (starve_cnt),
    .idle        (idle),
    .if_ready    (if_req_ready),
    .d_ready     (d_req_ready),
    .grant_owner (grant_owner)
  );

  assign acc_if = if_req_valid & if_req_ready;
  assign acc_d  = d_req_valid & d_req_ready;
  assign accept = acc_if | acc_d;
  assign from_d = (grant_owner == OWN_D);
  assign last   = (state == ST_ACCESS) && (cnt == 4'd0);

  // Payload of the granted requester; fetch is a word load.
  always_comb begin
    req_addr  = from_d ? d_addr : if_addr;
    req_size  = from_d ? d_size : SIZE_WORD;
    req_we    = from_d & d_we;
    req_wdata = from_d ? d_wdata : 32'd0;
    req_bad   = misaligned(req_addr[1:0], req_size);
  end

  // Next state: faulty accepts never leave IDLE.
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:   if (accept && !req_bad) state_nx = ST_ACCESS;
      ST_ACCESS: if (cnt == 4'd0) state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  // Memory drive: zero outside ACCESS, write on first cycle.
  always_comb begin
    mem_addr  = '0;
    mem_size  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    if (state == ST_ACCESS) begin
      mem_addr  = lat_addr;
      mem_size  = lat_size;
      mem_wdata = lat_wdata;
      mem_we    = lat_we & (cnt == CNT_INIT);
    end
  end

  // State, latency counter and request latches.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      lat_addr  <= '0;
      lat_size  <= '0;
      lat_we    <= 1'b0;
      lat_wdata <= '0;
      lat_owner <= OWN_IF;
    end else begin
      state <= state_nx;
      if (accept && !req_bad) begin
        cnt       <= CNT_INIT;
        lat_addr  <= req_addr;
        lat_size  <= req_size;
        lat_we    <= req_we;
        lat_wdata <= req_wdata;
        lat_owner <= grant_owner;
      end else if (state == ST_ACCESS && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  // Count data wins over a waiting fetch; a fetch win clears.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (acc_d && if_req_valid) begin
      if (starve_cnt != SCW'(STARVE_LIMIT))
        starve_cnt <= starve_cnt + 1'b1;
    end else if (acc_if) begin
      starve_cnt <= '0;
    end
  end

  // Registered responses: error pulse or end-of-access pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_rsp_valid <= 1'b0;
      if_rsp_data  <= '0;
      if_rsp_err   <= 1'b0;
      d_rsp_valid  <= 1'b0;
      d_rsp_data   <= '0;
      d_rsp_err    <= 1'b0;
    end else begin
      if_rsp_valid <= 1'b0;
      d_rsp_valid  <= 1'b0;
      if (accept && req_bad) begin
        if (acc_d) begin
          d_rsp_valid <= 1'b1;
          d_rsp_data  <= '0;
          d_rsp_err   <= 1'b1;
        end else begin
          if_rsp_valid <= 1'b1;
          if_rsp_data  <= '0;
          if_rsp_err   <= 1'b1;
        end
      end else if (last) begin
        if (lat_owner == OWN_D) begin
          d_rsp_valid <= 1'b1;
          d_rsp_data  <= lat_we ? 32'd0 : mem_rdata;
          d_rsp_err   <= 1'b0;
        end else begin
          if_rsp_valid <= 1'b1;
          if_rsp_data  <= mem_rdata;
          if_rsp_err   <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: vector table plus
// sequences for arbitration, starvation, reset, LATENCY=1.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        if_req_valid, if_req_ready;
  logic [31:0] if_addr;
  logic        if_rsp_valid, if_rsp_err;
  logic [31:0] if_rsp_data;
  logic        d_req_valid, d_req_ready;
  logic [31:0] d_addr, d_wdata;
  logic [1:0]  d_size;
  logic        d_we;
  logic        d_rsp_valid, d_rsp_err;
  logic [31:0] d_rsp_data;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  mem_size;
  logic        mem_we;

  logic        b_if_req_valid, b_if_req_ready;
  logic [31:0] b_if_addr;
  logic        b_if_rsp_valid, b_if_rsp_err;
  logic [31:0] b_if_rsp_data;
  logic        b_d_req_valid, b_d_req_ready;
  logic [31:0] b_d_addr, b_d_wdata;
  logic [1:0]  b_d_size;
  logic        b_d_we;
  logic        b_d_rsp_valid, b_d_rsp_err;
  logic [31:0] b_d_rsp_data;
  logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic [1:0]  b_mem_size;
  logic        b_mem_we;

  mem_port_arbiter #(.LATENCY(2), .STARVE_LIMIT(4)) u_dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready),
    .if_addr(if_addr), .if_rsp_valid(if_rsp_valid),
    .if_rsp_data(if_rsp_data), .if_rsp_err(if_rsp_err),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready),
    .d_addr(d_addr), .d_size(d_size), .d_we(d_we),
    .d_wdata(d_wdata), .d_rsp_valid(d_rsp_valid),
    .d_rsp_data(d_rsp_data), .d_rsp_err(d_rsp_err),
    .mem_addr(mem_addr), .mem_size(mem_size),
    .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.LATENCY(1), .STARVE_LIMIT(4)) u_dut1 (
    .clk(clk), .rst(rst),
    .if_req_valid(b_if_req_valid), .if_req_ready(b_if_req_ready),
    .if_addr(b_if_addr), .if_rsp_valid(b_if_rsp_valid),
    .if_rsp_data(b_if_rsp_data), .if_rsp_err(b_if_rsp_err),
    .d_req_valid(b_d_req_valid), .d_req_ready(b_d_req_ready),
    .d_addr(b_d_addr), .d_size(b_d_size), .d_we(b_d_we),
    .d_wdata(b_d_wdata), .d_rsp_valid(b_d_rsp_valid),
    .d_rsp_data(b_d_rsp_data), .d_rsp_err(b_d_rsp_err),
    .mem_addr(b_mem_addr), .mem_size(b_mem_size),
    .mem_wdata(b_mem_wdata), .mem_we(b_mem_we),
    .mem_rdata(b_mem_rdata)
  );

  // Memory model: combinational read, byte-lane writes.
  logic [31:0] mem [0:255];
  logic        preloaded = 1'b0;
  assign mem_rdata   = mem[mem_addr[9:2]];
  assign b_mem_rdata = mem[b_mem_addr[9:2]];

  always @(posedge clk) begin
    if (!preloaded) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'd0;
      mem[0]     <= 32'h1111_1111;
      mem[1]     <= 32'h2222_2222;
      mem[2]     <= 32'h3333_3333;
      mem[8'h40] <= 32'hDEAD_BEEF;
      preloaded  <= 1'b1;
    end else if (mem_we) begin
      case (mem_size)
        2'b00: mem[mem_addr[9:2]][{mem_addr[1:0], 3'b000} +: 8]
                 <= mem_wdata[7:0];
        2'b01: mem[mem_addr[9:2]][{mem_addr[1], 4'b0000} +: 16]
                 <= mem_wdata[15:0];
        default: mem[mem_addr[9:2]] <= mem_wdata;
      endcase
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        is_d;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        we;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_data;
    int          exp_lat;
    int          exp_we;
  } vec_t;

  vec_t vecs [11];

  // One request on instance A; waits for accept and response.
  task automatic do_req(input vec_t v, output int acc_n,
                        output logic got, output logic err,
                        output logic [31:0] data, output int lat,
                        output int wes, output logic addr_ok);
    logic acc;
    logic rsp;
    logic [31:0] exp_ma;
    got = 0; err = 0; data = 0; lat = 0; wes = 0;
    addr_ok = 1; acc = 0; acc_n = 0;
    @(posedge clk); #1;
    if (v.is_d) begin
      d_req_valid = 1; d_addr = v.addr; d_size = v.size;
      d_we = v.we; d_wdata = v.wdata;
    end else begin
      if_req_valid = 1; if_addr = v.addr;
    end
    while (!acc && acc_n < 20) begin
      @(negedge clk);
      acc = v.is_d ? d_req_ready : if_req_ready;
      acc_n++;
      if (!acc) @(posedge clk);
    end
    @(posedge clk); #1;
    d_req_valid = 0; if_req_valid = 0;
    d_addr = 0; d_size = 0; d_we = 0; d_wdata = 0; if_addr = 0;
    for (int k = 1; k <= 30 && !got; k++) begin
      @(negedge clk);
      lat = k;
      if (mem_we) wes++;
      exp_ma = (!v.exp_err && k < v.exp_lat) ? v.addr : 32'd0;
      if (mem_addr !== exp_ma) addr_ok = 0;
      rsp = v.is_d ? d_rsp_valid : if_rsp_valid;
      if (rsp) begin
        got  = 1;
        err  = v.is_d ? d_rsp_err : if_rsp_err;
        data = v.is_d ? d_rsp_data : if_rsp_data;
      end
    end
  endtask

  task automatic run_vec(input string nm, input vec_t v);
    int acc_n, lat, wes;
    logic got, err, aok;
    logic [31:0] data;
    do_req(v, acc_n, got, err, data, lat, wes, aok);
    chk({nm, "_accept_cycle"}, acc_n, 1);
    chk({nm, "_rsp_seen"}, {31'd0, got}, 1);
    chk({nm, "_err"}, {31'd0, err}, {31'd0, v.exp_err});
    chk({nm, "_data"}, data, v.exp_data);
    chk({nm, "_latency"}, lat, v.exp_lat);
    chk({nm, "_we_cycles"}, wes, v.exp_we);
    chk({nm, "_mem_addr"}, {31'd0, aok}, 1);
  endtask

  initial begin
    vec_t tmp;
    int n, g, nr, idx, cyc;
    logic acc, bad, quiet;
    logic [31:0] rd;
    int rsp_cyc [3];
    int acc_cyc [3];
    logic [31:0] rsp_dat [3];
    string gexp;

    //            is_d addr      sz     we wdata         err dat           lat we
    vecs[0]  = '{1'b1, 32'h100, 2'b10, 1'b0, 32'h0,       1'b0, 32'hDEADBEEF, 3, 0};
    vecs[1]  = '{1'b1, 32'h040, 2'b10, 1'b1, 32'h12345678, 1'b0, 32'h0,       3, 1};
    vecs[2]  = '{1'b1, 32'h040, 2'b10, 1'b0, 32'h0,       1'b0, 32'h12345678, 3, 0};
    vecs[3]  = '{1'b1, 32'h102, 2'b10, 1'b0, 32'h0,       1'b1, 32'h0,        1, 0};
    vecs[4]  = '{1'b1, 32'h103, 2'b01, 1'b0, 32'h0,       1'b1, 32'h0,        1, 0};
    vecs[5]  = '{1'b1, 32'h010, 2'b11, 1'b1, 32'h5,       1'b1, 32'h0,        1, 0};
    vecs[6]  = '{1'b0, 32'h006, 2'b10, 1'b0, 32'h0,       1'b1, 32'h0,        1, 0};
    vecs[7]  = '{1'b0, 32'h100, 2'b10, 1'b0, 32'h0,       1'b0, 32'hDEADBEEF, 3, 0};
    vecs[8]  = '{1'b1, 32'h102, 2'b01, 1'b0, 32'h0,       1'b0, 32'hDEADBEEF, 3, 0};
    vecs[9]  = '{1'b1, 32'h041, 2'b00, 1'b1, 32'hAB,      1'b0, 32'h0,        3, 1};
    vecs[10] = '{1'b1, 32'h040, 2'b10, 1'b0, 32'h0,       1'b0, 32'h1234AB78, 3, 0};

    b_d_req_valid = 0; b_d_addr = 0; b_d_size = 0;
    b_d_we = 0; b_d_wdata = 0;
    b_if_req_valid = 0; b_if_addr = 0;

    // Reset with both requesters asking: nothing may move.
    rst = 0;
    if_req_valid = 1; if_addr = 0;
    d_req_valid = 1; d_addr = 32'h100; d_size = 2'b10;
    d_we = 1; d_wdata = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("rst_if_ready", {31'd0, if_req_ready}, 0);
    chk("rst_d_ready", {31'd0, d_req_ready}, 0);
    chk("rst_mem_we", {31'd0, mem_we}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_rsp_valid", {30'd0, if_rsp_valid, d_rsp_valid}, 0);
    chk("rst_rsp_data", if_rsp_data | d_rsp_data, 0);
    @(posedge clk); #1;
    if_req_valid = 0; d_req_valid = 0;
    d_addr = 0; d_size = 0; d_we = 0; d_wdata = 0;
    rst = 1;

    for (int i = 0; i < 11; i++)
      run_vec($sformatf("v%0d", i), vecs[i]);

    // Store with fetch waiting: fetch wins the response cycle.
    @(posedge clk); #1;
    d_req_valid = 1; d_addr = 32'h44; d_size = 2'b10;
    d_we = 1; d_wdata = 32'hCAFEF00D;
    if_req_valid = 1; if_addr = 32'h0;
    @(negedge clk);
    chk("sf_d_ready", {30'd0, d_req_ready, if_req_ready}, 2);
    @(posedge clk); #1;
    d_req_valid = 0; d_we = 0;
    n = 0; g = 0; acc = 0; bad = 0;
    for (int k = 1; k <= 20 && !acc; k++) begin
      @(negedge clk);
      if (mem_we) g++;
      if (if_req_ready) begin
        acc = 1; n = k; bad = !d_rsp_valid;
      end
    end
    chk("sf_fetch_grant_cycle", n, 3);
    chk("sf_grant_in_rsp_cycle", {31'd0, bad}, 0);
    chk("sf_we_cycles", g, 1);
    @(posedge clk); #1;
    if_req_valid = 0;
    n = 0; rd = 32'hX;
    for (int k = 1; k <= 10 && n == 0; k++) begin
      @(negedge clk);
      if (if_rsp_valid) begin n = k; rd = if_rsp_data; end
    end
    chk("sf_fetch_latency", n, 3);
    chk("sf_fetch_data", rd, 32'h1111_1111);
    tmp = '{1'b1, 32'h44, 2'b10, 1'b0, 32'h0, 1'b0,
            32'hCAFEF00D, 3, 0};
    run_vec("sf_load", tmp);

    // Reset in the first ACCESS cycle of a store.
    @(posedge clk); #1;
    d_req_valid = 1; d_addr = 32'h80; d_size = 2'b10;
    d_we = 1; d_wdata = 32'h55;
    @(negedge clk);
    chk("rr_accept", {31'd0, d_req_ready}, 1);
    @(posedge clk); #1;
    d_req_valid = 0; d_we = 0;
    if_req_valid = 1; if_addr = 32'h0;
    @(negedge clk);
    chk("rr_we_before", {31'd0, mem_we}, 1);
    #2 rst = 0;
    #1;
    chk("rr_we_async_drop", {31'd0, mem_we}, 0);
    chk("rr_ready_low", {30'd0, if_req_ready, d_req_ready}, 0);
    chk("rr_mem_addr", mem_addr, 0);
    chk("rr_rsp_data_clr", d_rsp_data, 0);
    @(posedge clk); #1;
    chk("rr_ready_low2", {30'd0, if_req_ready, d_req_ready}, 0);
    if_req_valid = 0;
    rst = 1;
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (d_rsp_valid || if_rsp_valid) bad = 1;
    end
    chk("rr_no_rsp", {31'd0, bad}, 0);
    chk("rr_store_dropped", mem[8'h20], 0);
    run_vec("rr_load", vecs[0]);

    // Both valid continuously: four data grants, then fetch.
    gexp = "DDDDIDDDDI";
    @(posedge clk); #1;
    d_req_valid = 1; d_addr = 32'h100; d_size = 2'b10; d_we = 0;
    if_req_valid = 1; if_addr = 32'h0;
    g = 0;
    for (int c = 0; c < 200 && g < 10; c++) begin
      @(negedge clk);
      if (d_req_ready || if_req_ready) begin
        chk($sformatf("starve_grant%0d", g),
            {30'd0, d_req_ready, if_req_ready},
            (gexp[g] == "D") ? 32'd2 : 32'd1);
        g++;
      end
    end
    chk("starve_grants", g, 10);
    @(posedge clk); #1;
    d_req_valid = 0; if_req_valid = 0;
    repeat (6) @(posedge clk);

    // LATENCY=1 instance: back-to-back fetches at 0, 4, 8.
    @(posedge clk); #1;
    b_if_req_valid = 1; b_if_addr = 0;
    idx = 0; nr = 0; cyc = 0; quiet = 1;
    for (int c = 0; c < 30 && nr < 3; c++) begin
      @(negedge clk);
      cyc++;
      if (b_if_rsp_valid) begin
        rsp_cyc[nr] = cyc; rsp_dat[nr] = b_if_rsp_data; nr++;
      end
      if (b_d_req_ready || b_d_rsp_valid || b_d_rsp_err ||
          b_if_rsp_err || b_mem_we || (b_d_rsp_data != 0) ||
          (b_mem_wdata != 0) || (b_mem_size == 2'b01) ||
          (b_mem_size == 2'b11))
        quiet = 0;
      acc = b_if_req_ready;
      @(posedge clk); #1;
      if (acc && idx < 3) begin
        acc_cyc[idx] = cyc;
        idx++;
        if (idx == 3) b_if_req_valid = 0;
        else b_if_addr = 32'(idx * 4);
      end
    end
    b_if_req_valid = 0;
    chk("l1_rsp_count", nr, 3);
    chk("l1_quiet", {31'd0, quiet}, 1);
    if (nr == 3 && idx == 3) begin
      chk("l1_data0", rsp_dat[0], 32'h1111_1111);
      chk("l1_data1", rsp_dat[1], 32'h2222_2222);
      chk("l1_data2", rsp_dat[2], 32'h3333_3333);
      for (int i = 0; i < 3; i++)
        chk($sformatf("l1_lat%0d", i), rsp_cyc[i] - acc_cyc[i], 2);
      chk("l1_gap01", rsp_cyc[1] - rsp_cyc[0], 2);
      chk("l1_gap12", rsp_cyc[2] - rsp_cyc[1], 2);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
